// File: rtl/pi_update.sv
// Multi-cycle PI control-law stage: samples setpoint/feedback on start, forms the
// error, and produces a saturated integral and control output via one shared multiplier.
module pi_update #(
  parameter int SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         ref_val,  // setpoint; "ref" is a reserved word
  input  logic [7:0]         fb,
  input  logic [7:0]         kp,
  input  logic [7:0]         ki,
  input  logic signed [8:0]  yk1,
  input  logic signed [16:0] ik1,
  output logic signed [8:0]  yk,
  output logic signed [16:0] ik,
  output logic               save,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, ERR, MULP, MULI, INTEG, OUT} state_t;

  state_t             state, state_nx;
  logic [7:0]         ref_l, fb_l, kp_l, ki_l;
  logic signed [16:0] ik1_l;
  logic signed [8:0]  e;
  logic signed [16:0] pterm, iprod, inew;

  logic [7:0]         mul_k;
  logic signed [17:0] prod;
  logic signed [17:0] isum;
  logic signed [16:0] isat;
  logic signed [18:0] u, ushift;
  logic signed [8:0]  ysat;
  logic               unused;

  // yk1 is reserved for future rate logic; prod[17] is always a sign copy.
  assign unused = ^{yk1, prod[17]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ERR;
      ERR:     state_nx = MULP;
      MULP:    state_nx = MULI;
      MULI:    state_nx = INTEG;
      INTEG:   state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Single multiplier time-shared between the proportional and integral products.
  assign mul_k = (state == MULI) ? ki_l : kp_l;
  assign prod  = e * $signed({1'b0, mul_k});

  assign isum = {ik1_l[16], ik1_l} + {iprod[16], iprod};
  always_comb begin
    isat = isum[16:0];
    if (isum > 18'sd65535)       isat = 17'sh0FFFF;
    else if (isum < -18'sd65536) isat = 17'sh10000;
  end

  assign u      = {{2{pterm[16]}}, pterm} + {{2{inew[16]}}, inew};
  assign ushift = u >>> SHIFT;
  always_comb begin
    ysat = ushift[8:0];
    if (ushift > 19'sd255)       ysat = 9'sh0FF;
    else if (ushift < -19'sd256) ysat = 9'sh100;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ref_l <= '0;
      fb_l  <= '0;
      kp_l  <= '0;
      ki_l  <= '0;
      ik1_l <= '0;
      e     <= '0;
      pterm <= '0;
      iprod <= '0;
      inew  <= '0;
      yk    <= '0;
      ik    <= '0;
      save  <= 1'b0;
    end else begin
      state <= state_nx;
      save  <= (state == OUT);
      case (state)
        IDLE: if (start) begin
          ref_l <= ref_val;
          fb_l  <= fb;
          kp_l  <= kp;
          ki_l  <= ki;
          ik1_l <= ik1;
        end
        ERR:   e     <= $signed({1'b0, ref_l}) - $signed({1'b0, fb_l});
        MULP:  pterm <= prod[16:0];
        MULI:  iprod <= prod[16:0];
        INTEG: inew  <= isat;
        OUT: begin
          yk <= ysat;
          ik <= inew;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_update.sv
// Scoreboard bench for pi_update: stimulus pushes expected (yk, ik) pairs, a monitor
// pops and compares on every save strobe.
module tb_pi_update;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [7:0]         ref_val, fb, kp, ki;
  logic signed [8:0]  yk1;
  logic signed [16:0] ik1;
  logic signed [8:0]  yk;
  logic signed [16:0] ik;
  logic               save, busy;

  typedef struct {
    logic signed [8:0]  y;
    logic signed [16:0] i;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   saves  = 0;

  pi_update #(.SHIFT(6)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_val(ref_val), .fb(fb),
    .kp(kp), .ki(ki), .yk1(yk1), .ik1(ik1), .yk(yk), .ik(ik),
    .save(save), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every save must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (save) begin
      saves++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_save: got yk=%0d ik=%0d, expected no save", yk, ik);
      end else begin
        exp_t x;
        x = q.pop_front();
        check("yk", longint'(yk), longint'(x.y));
        check("ik", longint'(ik), longint'(x.i));
      end
    end
  end

  task automatic drive(input logic [7:0] r, input logic [7:0] f, input logic [7:0] p,
                       input logic [7:0] k, input logic signed [16:0] i1);
    ref_val = r; fb = f; kp = p; ki = k; ik1 = i1;
    yk1 = 9'($urandom_range(0, 511));
  endtask

  // Runs one update and checks latency, busy length and save pulse width.
  task automatic run(input logic [7:0] r, input logic [7:0] f, input logic [7:0] p,
                     input logic [7:0] k, input logic signed [16:0] i1,
                     input logic signed [8:0] ey, input logic signed [16:0] ei);
    int lat, bcnt;
    exp_t x;
    @(negedge clk);
    drive(r, f, p, k, i1);
    start = 1'b1;
    x.y = ey; x.i = ei;
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 8'd0, 17'sd0);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!save && lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    check("latency", lat, 5);
    check("busy_cycles", bcnt, 5);
    @(negedge clk);
    check("save_width", save, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 8'd0, 17'sd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_yk", yk, 0);
    check("rst_ik", ik, 0);
    check("rst_save", save, 0);
    check("rst_busy", busy, 0);
    idle(20);
    check("idle_saves", saves, 0);

    run(8'd200, 8'd100, 8'd16, 8'd4, 17'sd0, 9'sd31, 17'sd400);
    run(8'd100, 8'd101, 8'd1, 8'd1, 17'sd0, -9'sd1, -17'sd1);
    run(8'd255, 8'd0, 8'd255, 8'd255, 17'sd65000, 9'sd255, 17'sd65535);
    run(8'd0, 8'd255, 8'd255, 8'd255, 17'sh10000, 9'sh100, 17'sh10000);
    run(8'd50, 8'd10, 8'd0, 8'd3, -17'sd200, -9'sd2, -17'sd80);
    // yk held after save
    idle(3);
    check("hold_yk", yk, -2);
    check("hold_ik", ik, -80);

    // Starts during busy and on the OUT->IDLE edge must be ignored.
    begin
      exp_t x;
      int s0;
      s0 = saves;
      @(negedge clk);
      drive(8'd200, 8'd100, 8'd16, 8'd4, 17'sd0);
      start = 1'b1;
      x.y = 9'sd31; x.i = 17'sd400;
      q.push_back(x);
      @(posedge clk);
      @(negedge clk);
      drive(8'd10, 8'd200, 8'd16, 8'd4, 17'sd0);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;           // in MULP
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;           // in OUT, same edge as return to IDLE
      @(negedge clk);
      start = 1'b0;
      idle(12);
      check("ignored_starts", saves - s0, 1);
    end

    // Reset in MULI aborts the update.
    @(negedge clk);
    drive(8'd100, 8'd101, 8'd1, 8'd1, 17'sd0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);           // ERR
    start = 1'b0;
    @(negedge clk);           // MULP
    @(negedge clk);           // MULI
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_yk", yk, 0);
    check("abort_ik", ik, 0);
    check("abort_busy", busy, 0);
    check("abort_save", save, 0);
    begin
      int s1;
      s1 = saves;
      idle(10);
      check("abort_no_save", saves - s1, 0);
    end

    run(8'd200, 8'd100, 8'd16, 8'd4, 17'sd0, 9'sd31, 17'sd400);
    idle(4);
    check("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
